// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives imem, buffers {pc,instr} into a prefetch FIFO for decode.
// Latency: fetch_en seen at edge E0 -> first push at E1 -> if_valid after E1; 1 instr/cycle sustained.
// Backpressure: when the FIFO is full and decode is not ready, no fetch is issued and the PC holds.

module imem_fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdat_i,
    output logic [W-1:0]  rdat_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            // Flush wins over any concurrent push; the pop side just loses its entry.
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdat_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign rdat_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          run;
    logic          push, pop;
    logic [CW-1:0] count;
    fetch_ent_t    wr_ent, head_ent;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_en)  state_d = RUN;
            RUN:     if (!fetch_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        run = (state_q == RUN);
    end

    assign imem_addr = pc_q & 32'hFFFF_FFFC;
    assign if_valid  = (count != '0);
    assign pop       = if_valid & if_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still streams.
    assign push      = run & ~redirect_valid & ((count < CW'(DEPTH)) | pop);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) pc_d = redirect_pc & 32'hFFFF_FFFC;
        else if (push)      pc_d = imem_addr + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC & 32'hFFFF_FFFC;
        else        pc_q <= pc_d;
    end

    assign wr_ent.pc    = imem_addr;
    assign wr_ent.instr = imem_instr;

    imem_fetch_fifo #(
        .W     ($bits(fetch_ent_t)),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .wdat_i  (wr_ent),
        .rdat_o  (head_ent),
        .count_o (count)
    );

    // Head is masked while empty so stale storage never leaks onto the decode bus.
    assign if_pc    = if_valid ? head_ent.pc    : 32'd0;
    assign if_instr = if_valid ? head_ent.instr : 32'd0;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed vector table, corner-case sequences and random traffic vs a queue model.
module tb_imem_fetch_ctrl;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        if_ready = 1'b0;
    logic [31:0] imem_addr, imem_instr, if_instr, if_pc;
    logic        if_valid;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h0060_0113;
            32'h8:   return 32'h0020_81b3;
            32'hC:   return 32'h0000_0013;
            default: return 32'h0000_0013;
        endcase
    endfunction

    assign imem_instr = mem_rd(imem_addr);

    imem_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of fetched {pc,instr} pairs, a PC and a run flag.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_run;

    task automatic model_reset();
        mq.delete();
        m_pc  = 32'h0;
        m_run = 1'b0;
    endtask

    task automatic model_check(input string tag);
        chk({tag, " valid"}, {31'd0, if_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
        chk({tag, " addr"}, imem_addr, m_pc);
        if (mq.size() != 0) begin
            chk({tag, " pc"}, if_pc, mq[0].pc);
            chk({tag, " instr"}, if_instr, mq[0].instr);
        end
    endtask

    task automatic step(input bit fe, input bit rv, input logic [31:0] rpc, input bit rdy, input string tag);
        bit pop, push;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        @(posedge clk);
        pop  = (mq.size() != 0) && rdy;
        push = m_run && !rv && ((mq.size() < DEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (rv) begin
            mq.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
        end else if (push) begin
            mq.push_back(ent_t'{pc: m_pc, instr: mem_rd(m_pc)});
            m_pc = m_pc + 32'd4;
        end
        m_run = fe;
        #1;
        model_check(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        #1;
        model_reset();
        chk("rst valid", {31'd0, if_valid}, 32'd0);
        chk("rst addr", imem_addr, 32'd0);
        chk("rst if_pc", if_pc, 32'd0);
        chk("rst if_instr", if_instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          rst;
        bit          fe;
        bit          rdy;
        bit          vld;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] addr;
    } vec_t;

    vec_t vt[$];

    initial begin
        // Streaming, then back-pressure from reset.
        vt.push_back('{1, 1, 1, 0, 32'h0, 32'h0,          32'h0});
        vt.push_back('{0, 1, 1, 1, 32'h0, 32'h0050_0093, 32'h4});
        vt.push_back('{0, 1, 1, 1, 32'h4, 32'h0060_0113, 32'h8});
        vt.push_back('{0, 1, 1, 1, 32'h8, 32'h0020_81b3, 32'hC});
        vt.push_back('{0, 1, 1, 1, 32'hC, 32'h0000_0013, 32'h10});
        vt.push_back('{1, 1, 0, 0, 32'h0, 32'h0,          32'h0});
        vt.push_back('{0, 1, 0, 1, 32'h0, 32'h0050_0093, 32'h4});
        vt.push_back('{0, 1, 0, 1, 32'h0, 32'h0050_0093, 32'h8});
        vt.push_back('{0, 1, 0, 1, 32'h0, 32'h0050_0093, 32'h8});
        vt.push_back('{0, 1, 1, 1, 32'h4, 32'h0060_0113, 32'hC});
        vt.push_back('{0, 1, 1, 1, 32'h8, 32'h0020_81b3, 32'h10});

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset();
            step(vt[i].fe, 1'b0, 32'h0, vt[i].rdy, "vec model");
            chk("vec valid", {31'd0, if_valid}, {31'd0, vt[i].vld});
            chk("vec addr", imem_addr, vt[i].addr);
            if (vt[i].vld) begin
                chk("vec pc", if_pc, vt[i].pc);
                chk("vec instr", if_instr, vt[i].instr);
            end
        end

        // Redirect to an unaligned target while streaming at pc=0x8.
        do_reset();
        step(1, 0, 32'h0, 1, "redir");
        step(1, 0, 32'h0, 1, "redir");
        step(1, 0, 32'h0, 1, "redir");
        step(1, 1, 32'h0000_0005, 1, "redir");
        chk("redir flush valid", {31'd0, if_valid}, 32'd0);
        chk("redir addr", imem_addr, 32'h4);
        step(1, 0, 32'h0, 1, "redir");
        chk("redir head pc", if_pc, 32'h4);
        chk("redir head instr", if_instr, 32'h0060_0113);

        // Stop after the 0x4 push, drain, then restart.
        do_reset();
        step(1, 0, 32'h0, 1, "stop");
        step(1, 0, 32'h0, 1, "stop");
        step(0, 0, 32'h0, 1, "stop");
        step(0, 0, 32'h0, 1, "stop");
        step(0, 0, 32'h0, 1, "stop");
        chk("stop valid", {31'd0, if_valid}, 32'd0);
        chk("stop addr hold", imem_addr, 32'h8);
        step(1, 0, 32'h0, 1, "restart");
        step(1, 0, 32'h0, 1, "restart");
        chk("restart pc", if_pc, 32'h8);
        chk("restart instr", if_instr, 32'h0020_81b3);

        // PC wrap through the top of the address space.
        do_reset();
        step(1, 0, 32'h0, 1, "wrap");
        step(1, 0, 32'h0, 1, "wrap");
        step(1, 1, 32'hFFFF_FFF8, 0, "wrap");
        step(1, 0, 32'h0, 0, "wrap");
        chk("wrap head0 pc", if_pc, 32'hFFFF_FFF8);
        chk("wrap unmapped instr", if_instr, 32'h0000_0013);
        step(1, 0, 32'h0, 0, "wrap");
        step(1, 0, 32'h0, 1, "wrap");
        chk("wrap head1 pc", if_pc, 32'hFFFF_FFFC);
        step(1, 0, 32'h0, 1, "wrap");
        chk("wrap head2 pc", if_pc, 32'h0);
        chk("wrap head2 instr", if_instr, 32'h0050_0093);

        // Asynchronous reset with a full FIFO, away from any clock edge.
        do_reset();
        step(1, 0, 32'h0, 0, "arst");
        step(1, 0, 32'h0, 0, "arst");
        step(1, 0, 32'h0, 0, "arst");
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst valid", {31'd0, if_valid}, 32'd0);
        chk("arst addr", imem_addr, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 32'h0, 1, "arst");
        step(1, 0, 32'h0, 1, "arst");
        chk("arst head pc", if_pc, 32'h0);
        chk("arst head instr", if_instr, 32'h0050_0093);

        // Random traffic against the model.
        do_reset();
        repeat (500) begin
            bit          fe, rv, rdy;
            logic [31:0] rpc;
            fe  = ($urandom % 8) != 0;
            rv  = ($urandom % 20) == 0;
            rdy = ($urandom % 3) != 0;
            rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : ($urandom % 64);
            step(fe, rv, rpc, rdy, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer that sits between the combinational imem (addr -> instruction, same cycle) and the decode stage. It owns the program counter and drives word-aligned addresses into imem. It captures each returned {pc, instruction} pair into a small prefetch FIFO and presents the FIFO head to decode over a valid/ready handshake. It also supports start/stop and single-cycle PC redirect with buffer flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset.
DEPTH, 2, prefetch FIFO entries; must be >= 1.

Ports:
clk  input  1  clock, rising edge; the only clock.
rst_n  input  1  asynchronous active-low reset.
fetch_en  input  1  level; 1 = issue fetches, 0 = stop issuing.
redirect_valid  input  1  single-cycle redirect request.
redirect_pc  input  32  redirect target.
imem_addr  output  32  address to imem, always {pc[31:2],2'b00}.
imem_instr  input  32  instruction returned combinationally by imem.
if_valid  output  1  FIFO head valid.
if_ready  input  1  decode accepts the head.
if_instr  output  32  head instruction.
if_pc  output  32  head PC, word-aligned.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=IDLE, FIFO count=0, rd/wr pointers=0, if_valid=0, if_instr=0, if_pc=0.
- FSM states:
  - IDLE: no enqueue. fetch_en=1 at a rising edge -> RUN.
  - RUN: fetch_en=0 at a rising edge -> IDLE. FIFO contents remain and keep draining.
- imem_addr is combinational from the pc register. The low 2 bits are always 0.
- pop = if_valid & if_ready.
- push = (state==RUN) & ~redirect_valid & (count<DEPTH | pop).
- On push: enqueue {imem_addr, imem_instr} and set pc <= pc+4. PC wraps mod 2^32, so 32'hFFFF_FFFC -> 0.
- Simultaneous push and pop at full is allowed; count is unchanged.
- Simultaneous push and pop at empty: the new entry becomes the head next cycle. There is no bypass.
- if_valid = (count!=0). if_instr and if_pc come from the head entry. They must hold stable while if_valid=1 and if_ready=0.
- Latency:
  - fetch_en seen at edge E0 -> RUN. First push at E1. if_valid=1 after E1.
  - Throughput is 1 instr/cycle with if_ready held 1.
- Redirect (any state), with redirect_valid=1 at an edge:
  - A pop in the same cycle still completes.
  - All FIFO entries are discarded: count=0, pointers reset.
  - pc <= {redirect_pc[31:2],2'b00}.
  - No push occurs in that cycle. State is unchanged.
  - In RUN, the first fetch from the target is pushed at the next edge.
- Redirect takes priority over push. fetch_en going low in the same cycle as a redirect is still honoured (-> IDLE).
- Reset mid-operation: everything returns immediately to reset values. A pending handshake is lost.
- Back-pressure: if_ready=0 with the FIFO full -> no push, pc holds, imem_addr stable.

Test Plan:
1. Imem holds 0x0=00500093, 0x4=00600113, 0x8=002081b3, 0xC=00000013. Reset, fetch_en=1, if_ready=1 -> if_valid rises two edges after fetch_en. Consecutive cycles then give (if_pc,if_instr)=(0,00500093),(4,00600113),(8,002081b3),(C,00000013).
2. Back-pressure: if_ready=0 from the start -> count saturates at DEPTH=2 and imem_addr holds 0x8. Head stays (0,00500093). Releasing if_ready drains 0,4,8 with no gap or duplicate.
3. Redirect: while streaming at pc=0x8, pulse redirect_valid with redirect_pc=0x0000_0005 -> FIFO flushed and next head is (4,00600113). No stale 0x8/0xC entry appears.
4. Stop/restart: drop fetch_en after the 0x4 push -> remaining entries drain, then if_valid=0 and imem_addr holds 0x8. Re-assert -> stream resumes at (8,002081b3).
5. Wrap and unmapped memory: redirect to 32'hFFFF_FFF8 -> heads FFFF_FFF8, FFFF_FFFC, 0000_0000, in order. Unmapped words read 00000013.
6. Reset mid-stream: assert rst_n=0 while if_valid=1 and the FIFO is full -> if_valid=0, imem_addr=0 immediately without waiting for a clock. After release and fetch_en, first head is (0,00500093).
